// File: rtl/rv_pkg.sv
// Shared register-file types and default sizes for the semi-core datapath.
package rv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

  typedef logic [$clog2(NREG_DEF)-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus between decode/writeback and the multi-port register file.
interface regfile_mp_if
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
) ();

  logic                clr_req;
  logic                busy;
  logic                wr_en;
  logic [AW-1:0]       wr_idx;
  logic [XLEN-1:0]     wr_data;
  logic [NRD*AW-1:0]   rd_idx;
  logic [NRD*XLEN-1:0] rd_data;

  modport master (
    output clr_req, wr_en, wr_idx, wr_data, rd_idx,
    input  busy, rd_data
  );

  modport slave (
    input  clr_req, wr_en, wr_idx, wr_data, rd_idx,
    output busy, rd_data
  );

endinterface

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks indices 1..NREG-1 writing zero, after reset or on request.
module regfile_clr_seq
  import rv_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req_i,
  output logic          busy_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_idx_o
);

  localparam logic [AW-1:0] IDX_ONE  = AW'(1);
  localparam logic [AW-1:0] IDX_LAST = AW'(NREG - 1);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // State and counter registers; reset starts a clear at index 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RF_CLEAR;
      cnt_q   <= IDX_ONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; clr_req during CLEAR is deliberately not a restart.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_CLEAR: begin
        if (cnt_q == IDX_LAST) begin
          state_d = RF_IDLE;
          cnt_d   = IDX_ONE;
        end else begin
          cnt_d   = cnt_q + IDX_ONE;
        end
      end
      RF_IDLE: begin
        if (clr_req_i) begin
          state_d = RF_CLEAR;
          cnt_d   = IDX_ONE;
        end else begin
          cnt_d   = IDX_ONE;
        end
      end
      default: begin
        state_d = RF_CLEAR;
        cnt_d   = IDX_ONE;
      end
    endcase
  end

  assign busy_o    = (state_q == RF_CLEAR);
  assign clr_we_o  = (state_q == RF_CLEAR);
  assign clr_idx_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// NRD-read / 1-write register file with x0 hardwired to zero and a built-in clear.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  logic                busy_s;
  logic                clr_we_s;
  logic [AW-1:0]       clr_idx_s;
  logic                wr_fire_s;
  logic [NRD*XLEN-1:0] rd_data_s;
  logic [XLEN-1:0]     gpr_q [NREG];

  regfile_clr_seq #(
    .NREG (NREG),
    .AW   (AW)
  ) u_clr_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_req_i (bus.clr_req),
    .busy_o    (busy_s),
    .clr_we_o  (clr_we_s),
    .clr_idx_o (clr_idx_s)
  );

  assign wr_fire_s = !busy_s && bus.wr_en && (bus.wr_idx != {AW{1'b0}});

  // Storage has no reset; the clear sequencer owns the write port while busy.
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      gpr_q[clr_idx_s] <= {XLEN{1'b0}};
    end else if (wr_fire_s) begin
      gpr_q[bus.wr_idx] <= bus.wr_data;
    end
  end

  // Combinational read ports; entry 0 is never stored, only muxed to zero.
  always_comb begin : rd_mux
    logic [AW-1:0] sel;
    sel       = {AW{1'b0}};
    rd_data_s = {(NRD*XLEN){1'b0}};
    for (int k = 0; k < NRD; k++) begin
      sel = bus.rd_idx[k*AW +: AW];
      if (busy_s || (sel == {AW{1'b0}})) begin
        rd_data_s[k*XLEN +: XLEN] = {XLEN{1'b0}};
`ifdef REGFILE_BYPASS_EN
      end else if (wr_fire_s && (sel == bus.wr_idx)) begin
        rd_data_s[k*XLEN +: XLEN] = bus.wr_data;
`endif
      end else begin
        rd_data_s[k*XLEN +: XLEN] = gpr_q[sel];
      end
    end
  end

  assign bus.busy    = busy_s;
  assign bus.rd_data = rd_data_s;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard-driven bench for regfile_mp (NREG=32, NRD=2, XLEN=32).
module tb_regfile_mp;
  import rv_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  typedef struct {
    string           name;
    logic [AW-1:0]   idx0;
    logic [AW-1:0]   idx1;
    logic [XLEN-1:0] exp0;
    logic [XLEN-1:0] exp1;
  } rd_item_t;

  logic clk = 1'b0;
  logic rst;
  rd_item_t        sb_q[$];
  logic [XLEN-1:0] model [NREG];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .AW(AW)) bus ();

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic push_read(input string name, input logic [AW-1:0] i0, input logic [AW-1:0] i1);
    rd_item_t it;
    it.name = name;
    it.idx0 = i0;
    it.idx1 = i1;
    it.exp0 = (i0 == 5'd0) ? 32'd0 : model[i0];
    it.exp1 = (i1 == 5'd0) ? 32'd0 : model[i1];
    sb_q.push_back(it);
  endtask

  task automatic apply_read(input logic [AW-1:0] i0, input logic [AW-1:0] i1,
                            output logic [XLEN-1:0] d0, output logic [XLEN-1:0] d1);
    bus.rd_idx = {i1, i0};
    #1;
    d0 = bus.rd_data[XLEN-1:0];
    d1 = bus.rd_data[2*XLEN-1:XLEN];
  endtask

  task automatic write_reg(input logic [AW-1:0] idx, input logic [XLEN-1:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_idx  = idx;
    bus.wr_data = data;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    if (idx != 5'd0) model[idx] = data;
  endtask

  task automatic count_busy(input int pulse_at, output int cycles);
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 200) begin
      bus.clr_req = (cycles == pulse_at);
      @(posedge clk);
      #1;
      cycles++;
    end
    bus.clr_req = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    rd_item_t it;
    logic [XLEN-1:0] d0, d1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    apply_read(5'd5, 5'd9, d0, d1);
    checks += 3;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", bus.busy); end
    if (d0 !== 32'd0) begin failures++; $display("FAIL reset_rd0 got=%h exp=0", d0); end
    if (d1 !== 32'd0) begin failures++; $display("FAIL reset_rd1 got=%h exp=0", d1); end
    rst = 1'b0;
    cyc = 0;
    // Attempt a write to x3 while clearing; it must be dropped.
    while (bus.busy === 1'b1 && cyc < 200) begin
      bus.wr_en   = (cyc == 5);
      bus.wr_idx  = 5'd3;
      bus.wr_data = 32'h0000_00FF;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.wr_en = 1'b0;
    checks++;
    if (cyc !== 31) begin failures++; $display("FAIL reset_busy_len got=%0d exp=31", cyc); end
    for (int i = 0; i < NREG; i++) model[i] = 32'd0;
    for (int i = 1; i < NREG; i++) push_read("reset_zero", 5'(i), 5'd3);
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      apply_read(it.idx0, it.idx1, d0, d1);
      checks += 2;
      if (d0 !== it.exp0) begin failures++; $display("FAIL %s p0 idx=%0d got=%h exp=%h", it.name, it.idx0, d0, it.exp0); end
      if (d1 !== it.exp1) begin failures++; $display("FAIL %s p1 idx=%0d got=%h exp=%h", it.name, it.idx1, d1, it.exp1); end
    end
  endtask

  task automatic test_write_read();
    rd_item_t it;
    logic [XLEN-1:0] d0, d1;
    write_reg(5'd5, 32'hDEAD_BEEF);
    push_read("wr_x5", 5'd5, 5'd5);
    write_reg(5'd0, 32'h0000_1234);
    push_read("wr_x0", 5'd0, 5'd0);
    write_reg(5'd31, 32'h8000_0001);
    write_reg(5'd1, 32'h7FFF_FFFE);
    push_read("wr_edges", 5'd31, 5'd1);
    push_read("wr_mixed", 5'd1, 5'd5);
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      apply_read(it.idx0, it.idx1, d0, d1);
      checks += 2;
      if (d0 !== it.exp0) begin failures++; $display("FAIL %s p0 idx=%0d got=%h exp=%h", it.name, it.idx0, d0, it.exp0); end
      if (d1 !== it.exp1) begin failures++; $display("FAIL %s p1 idx=%0d got=%h exp=%h", it.name, it.idx1, d1, it.exp1); end
    end
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] d0, d1, exp_same;
    write_reg(5'd7, 32'h1111_0000);
    bus.wr_en   = 1'b1;
    bus.wr_idx  = 5'd0;
    bus.wr_data = 32'hFFFF_FFFF;
    apply_read(5'd0, 5'd0, d0, d1);
    checks++;
    if (d0 !== 32'd0) begin failures++; $display("FAIL bypass_x0 got=%h exp=0", d0); end
    bus.wr_idx  = 5'd7;
    bus.wr_data = 32'hA5A5_A5A5;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'hA5A5_A5A5;
`else
    exp_same = 32'h1111_0000;
`endif
    apply_read(5'd7, 5'd7, d0, d1);
    checks += 2;
    if (d0 !== exp_same) begin failures++; $display("FAIL bypass_same p0 got=%h exp=%h", d0, exp_same); end
    if (d1 !== exp_same) begin failures++; $display("FAIL bypass_same p1 got=%h exp=%h", d1, exp_same); end
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    model[7]  = 32'hA5A5_A5A5;
    apply_read(5'd7, 5'd5, d0, d1);
    checks += 2;
    if (d0 !== 32'hA5A5_A5A5) begin failures++; $display("FAIL bypass_next got=%h exp=a5a5a5a5", d0); end
    if (d1 !== model[5]) begin failures++; $display("FAIL bypass_other got=%h exp=%h", d1, model[5]); end
  endtask

  task automatic test_fill_clear();
    int cyc;
    rd_item_t it;
    logic [XLEN-1:0] d0, d1;
    for (int i = 1; i < NREG; i++) write_reg(5'(i), 32'(i));
    for (int i = 1; i < NREG; i++) push_read("fill", 5'(i), 5'(NREG - i));
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      apply_read(it.idx0, it.idx1, d0, d1);
      checks += 2;
      if (d0 !== it.exp0) begin failures++; $display("FAIL %s p0 idx=%0d got=%h exp=%h", it.name, it.idx0, d0, it.exp0); end
      if (d1 !== it.exp1) begin failures++; $display("FAIL %s p1 idx=%0d got=%h exp=%h", it.name, it.idx1, d1, it.exp1); end
    end
    bus.clr_req = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_req = 1'b0;
    count_busy(10, cyc);
    checks++;
    if (cyc !== 31) begin failures++; $display("FAIL clr_req_busy_len got=%0d exp=31", cyc); end
    for (int i = 0; i < NREG; i++) model[i] = 32'd0;
    for (int i = 1; i < NREG; i++) push_read("clr_zero", 5'(i), 5'(NREG - i));
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      apply_read(it.idx0, it.idx1, d0, d1);
      checks += 2;
      if (d0 !== it.exp0) begin failures++; $display("FAIL %s p0 idx=%0d got=%h exp=%h", it.name, it.idx0, d0, it.exp0); end
      if (d1 !== it.exp1) begin failures++; $display("FAIL %s p1 idx=%0d got=%h exp=%h", it.name, it.idx1, d1, it.exp1); end
    end
  endtask

  task automatic test_reset_mid_clear();
    int cyc;
    rd_item_t it;
    logic [XLEN-1:0] d0, d1;
    write_reg(5'd9, 32'h0000_0099);
    write_reg(5'd20, 32'h2020_2020);
    bus.clr_req = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL midclr_busy got=%b exp=1", bus.busy); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    apply_read(5'd20, 5'd9, d0, d1);
    checks += 2;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL midclr_rst_busy got=%b exp=1", bus.busy); end
    if (d0 !== 32'd0) begin failures++; $display("FAIL midclr_rst_rd got=%h exp=0", d0); end
    rst = 1'b0;
    count_busy(-1, cyc);
    checks++;
    if (cyc !== 31) begin failures++; $display("FAIL midclr_busy_len got=%0d exp=31", cyc); end
    for (int i = 0; i < NREG; i++) model[i] = 32'd0;
    push_read("midclr_zero", 5'd9, 5'd20);
    push_read("midclr_zero", 5'd31, 5'd11);
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      apply_read(it.idx0, it.idx1, d0, d1);
      checks += 2;
      if (d0 !== it.exp0) begin failures++; $display("FAIL %s p0 idx=%0d got=%h exp=%h", it.name, it.idx0, d0, it.exp0); end
      if (d1 !== it.exp1) begin failures++; $display("FAIL %s p1 idx=%0d got=%h exp=%h", it.name, it.idx1, d1, it.exp1); end
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.clr_req = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_idx  = 5'd0;
    bus.wr_data = 32'd0;
    bus.rd_idx  = 10'd0;
    for (int i = 0; i < NREG; i++) model[i] = 32'd0;
    test_reset();
    test_write_read();
    test_bypass();
    test_fill_clear();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port general-purpose register file for the semi-core datapath. It provides NRD combinational read ports and one synchronous write port. Register 0 is hardwired to zero. A built-in clear sequencer zeroes the array one entry per cycle after reset, or on request, so the array needs no per-bit reset. It sits between decode (read indices) and writeback (write port); the pipeline stalls on `busy`.

## Interface
Parameters:
- `XLEN`, default 32: register width in bits.
- `NREG`, default 32: number of registers; power of two, at least 4.
- `NRD`, default 2: number of read ports, 1 to 4.
- `AW`, default $clog2(NREG): index width (derived; do not override).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clr_req`  in  1  one-cycle pulse; starts a full array clear.
- `busy`  out  1  high while the clear sequence runs.
- `wr_en`  in  1  write enable.
- `wr_idx`  in  AW  write index.
- `wr_data`  in  XLEN  write data.
- `rd_idx`  in  NRD*AW  packed read indices; port k uses bits [k*AW +: AW].
- `rd_data`  out  NRD*XLEN  packed read data; port k uses bits [k*XLEN +: XLEN].

## Operation
- States: CLEAR and IDLE.
- Reset (asynchronous, while `rst`=1): state=CLEAR, clear counter=1, `busy`=1.
- CLEAR:
  - Each rising edge writes zero to GPR[counter], then increments the counter.
  - When counter==NREG-1, that entry is written and the state moves to IDLE next edge.
  - `wr_en` is ignored and every `rd_data` port reads 0.
- IDLE:
  - `busy`=0.
  - `clr_req`=1 → CLEAR with counter=1 on the next edge. A write presented in that same cycle is still performed (it is later overwritten by the clear).
  - `clr_req` while already in CLEAR is ignored; it does not restart the sequence.
- Write: in IDLE, with `wr_en`=1 and `wr_idx`≠0, GPR[wr_idx] takes `wr_data` at the rising edge. A write to index 0 is discarded.
- Read: `rd_data` port k = 0 if rd_idx_k==0, else GPR[rd_idx_k]. Purely combinational; no clock.
- Any number of ports may read the same index, with identical results.
- Indices are always in range because NREG is a power of two.

## Timing
- Read latency: 0 cycles (combinational from `rd_idx`).
- Write visible on `rd_data` from the cycle after the write edge. Same-cycle visibility is available only with the bypass option (see Configuration).
- Clear duration: exactly NREG-1 cycles of `busy`=1 after `rst` deasserts, or after the edge that samples `clr_req`.
- `rst` asserted mid-clear: the counter returns to 1 and the sequence restarts.
- Reset values: `busy`=1 and all `rd_data`=0 while in reset.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - In IDLE, with `wr_en`=1, `wr_idx`≠0 and rd_idx_k==wr_idx, port k returns `wr_data` in the same cycle (write-through forwarding).
  - Index 0 is never bypassed.
- Not defined: port k returns the old GPR value until the next cycle. Writeback-to-decode forwarding must then be handled in the pipeline.

## Structure
- The shared package `rv_pkg` holds:
  - `XLEN_DEF`, `NREG_DEF` constants;
  - the `rf_state_t` enum (RF_IDLE, RF_CLEAR);
  - the `reg_idx_t` typedef.
- One sub-module, `regfile_clr_seq`:
  - contains the clear FSM and counter;
  - outputs `busy`, `clr_we` and `clr_idx`.
- Write-port muxing, storage and read ports stay in the top module.

## Test plan
- Reset release: pulse `rst` with NREG=32 → `busy`=1 for exactly 31 cycles, then 0. Reads of indices 1..31 then return 0.
- Write/read: write 0xDEADBEEF to x5, then read x5 on port 0 and port 1 in the next cycle → both 0xDEADBEEF. A write of 0x1234 to x0 → x0 reads 0.
- Bypass: write 0xA5A5A5A5 to x7 while rd_idx0=7 in the same cycle:
  - with `REGFILE_BYPASS_EN` → 0xA5A5A5A5 in that cycle;
  - without → old value, then 0xA5A5A5A5 next cycle.
- Writes ignored when busy: `wr_en` to x3 with 0xFF during CLEAR → x3 reads 0 after `busy` falls.
- `clr_req` in IDLE after filling x1..x31 with their own index → `busy` for 31 cycles, then all reads 0. A second `clr_req` mid-clear does not extend `busy`.
- Reset mid-clear: assert `rst` at clear cycle 10 → `busy` stays high and runs a full 31 cycles after `rst` release.
